// File: rtl/ps2_mouse_device_tx.sv
// PS/2 mouse device-side transmitter: serialises one 3-byte stream packet per handshake on open-drain lines.
// Build option PS2_DEV_RETRY_EN restarts an interrupted packet up to MAX_RETRY times before dropping it.
module ps2_mouse_device_tx #(
    parameter int CLK_HALF     = 4000,
    parameter int DATA_SETUP   = 2000,
    parameter int INHIBIT_WAIT = 5000,
    parameter int BYTE_GAP     = 8000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [8:0] dx,
    input  logic [8:0] dy,
    input  logic       xovf,
    input  logic       yovf,
    input  logic [2:0] buttons,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       aborted
);
    localparam int M1 = (CLK_HALF > INHIBIT_WAIT) ? CLK_HALF : INHIBIT_WAIT;
    localparam int M2 = (M1 > BYTE_GAP) ? M1 : BYTE_GAP;
    localparam int CW = $clog2(M2 + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] SETUP_AT = CW'(DATA_SETUP);
    localparam logic [CW-1:0] WAIT_END = CW'(INHIBIT_WAIT - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(BYTE_GAP - 1);

`ifdef PS2_DEV_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WAIT_BUS, BIT_HI, BIT_LO, GAP, DONE} state_t;
    state_t state, state_nx;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    byte0, byte1, byte2, cur_byte;
    logic [RW-1:0] retry_cnt;
    logic          data_oe_r, frame_bit;
    logic          handshake, hi_end, lo_end, byte_end, host_inhibit, retry_go;

    // A report is taken on the clock edge where pkt_valid and pkt_ready are both high;
    // pkt_ready is high only while IDLE, so pkt_valid held during a packet is ignored.
    assign handshake    = pkt_valid & pkt_ready;
    assign clk_s        = clk_sync[1];
    assign data_s       = data_sync[1];
    assign hi_end       = (cnt == HALF_END);
    assign lo_end       = (cnt == HALF_END);
    assign byte_end     = lo_end && (bit_idx == 4'd10);
    assign host_inhibit = (state == BIT_HI) && hi_end && !clk_s;
    assign retry_go     = RETRY_EN && (retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = byte0;
            2'd1:    cur_byte = byte1;
            default: cur_byte = byte2;
        endcase
        case (bit_idx)
            4'd0:    frame_bit = 1'b0;
            4'd9:    frame_bit = ~^cur_byte;
            4'd10:   frame_bit = 1'b1;
            default: frame_bit = cur_byte[3'(bit_idx - 4'd1)];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (handshake) state_nx = WAIT_BUS;
            WAIT_BUS: if (clk_s && data_s && cnt == WAIT_END) state_nx = BIT_HI;
            BIT_HI: begin
                if (hi_end) begin
                    if (!clk_s) state_nx = retry_go ? WAIT_BUS : IDLE;
                    else        state_nx = BIT_LO;
                end
            end
            BIT_LO: begin
                if (byte_end)    state_nx = (byte_idx == 2'd2) ? DONE : GAP;
                else if (lo_end) state_nx = BIT_HI;
            end
            GAP:      if (cnt == GAP_END) state_nx = WAIT_BUS;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            byte0     <= '0;
            byte1     <= '0;
            byte2     <= '0;
            retry_cnt <= '0;
            data_oe_r <= 1'b0;
        end else begin
            if (handshake) begin
                byte0     <= {yovf, xovf, dy[8], dx[8], 1'b1, buttons[1], buttons[2], buttons[0]};
                byte1     <= dx[7:0];
                byte2     <= dy[7:0];
                retry_cnt <= '0;
            end else if (host_inhibit && retry_go) begin
                retry_cnt <= retry_cnt + RW'(1);
            end

            // WAIT_BUS counts only consecutive cycles with both lines released
            if (state_nx != state || state == IDLE)            cnt <= '0;
            else if (state == WAIT_BUS && !(clk_s && data_s))  cnt <= '0;
            else                                               cnt <= cnt + CW'(1);

            if (state == WAIT_BUS)             bit_idx <= '0;
            else if (state == BIT_LO && lo_end) bit_idx <= bit_idx + 4'd1;

            if (handshake || host_inhibit)        byte_idx <= '0;
            else if (state == BIT_LO && byte_end) byte_idx <= byte_idx + 2'd1;

            if (state_nx != BIT_HI && state_nx != BIT_LO)  data_oe_r <= 1'b0;
            else if (state == BIT_HI && cnt == SETUP_AT)   data_oe_r <= ~frame_bit;
        end
    end

    always_comb begin
        pkt_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        if (!reset) begin
            pkt_ready   = (state == IDLE);
            busy        = (state != IDLE);
            done        = (state == DONE);
            aborted     = host_inhibit && !retry_go;
            ps2_clk_oe  = (state == BIT_LO);
            ps2_data_oe = data_oe_r;
        end
    end
endmodule
